// File: rtl/sensor_conditioner.sv
// Irrigation sensor front end: per-channel synchroniser and
// debounce, plus startup Valid flag and a Changed strobe.

module sensor_conditioner_channel #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic update
);

   localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [7:0]             cnt_q;
   logic                   s;
   logic                   differ;

   assign s      = sync_q[SYNC_STAGES-1];
   assign differ = s ^ level;
   assign update = differ && (cnt_q == LAST);

   // Shift the asynchronous raw bit through the synchroniser chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   // Count consecutive differing samples; flip the level when the run completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 8'd0;
         level <= 1'b0;
      end else if (!differ) begin
         cnt_q <= 8'd0;
      end else if (update) begin
         level <= s;
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

endmodule

module sensor_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic Clock,
   input  logic Reset,
   input  logic UmidadeArRaw,
   input  logic UmidadeSoloRaw,
   input  logic TemperaturaRaw,
   input  logic HighRaw,
   input  logic MediumRaw,
   input  logic LowRaw,
   output logic UmidadeAr,
   output logic UmidadeSolo,
   output logic Temperatura,
   output logic High,
   output logic Medium,
   output logic Low,
   output logic Valid,
   output logic Changed
);

   localparam int         SETTLE    = SYNC_STAGES + DEBOUNCE_CYCLES;
   localparam logic [8:0] SETTLE_M1 = 9'(SETTLE - 1);
   localparam logic [8:0] SETTLE_W  = 9'(SETTLE);

   logic [5:0] raw_bus;
   logic [5:0] level_bus;
   logic [5:0] update_bus;
   logic [8:0] settle_cnt;

   assign raw_bus = {UmidadeArRaw, UmidadeSoloRaw, TemperaturaRaw,
                     HighRaw, MediumRaw, LowRaw};

   assign {UmidadeAr, UmidadeSolo, Temperatura,
           High, Medium, Low} = level_bus;

   for (genvar i = 0; i < 6; i++) begin : g_ch
      sensor_conditioner_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk    (Clock),
         .rst    (Reset),
         .raw    (raw_bus[i]),
         .level  (level_bus[i]),
         .update (update_bus[i])
      );
   end

   // Count edges since reset release until the settle time is reached.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         settle_cnt <= 9'd0;
      end else if (settle_cnt < SETTLE_W) begin
         settle_cnt <= settle_cnt + 9'd1;
      end
   end

   // Valid rises on the settle edge and holds until the next reset.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         Valid <= 1'b0;
      end else if (settle_cnt == SETTLE_M1) begin
         Valid <= 1'b1;
      end
   end

   // Pulse Changed when any level flips, but only once already valid.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         Changed <= 1'b0;
      end else begin
         Changed <= Valid && (|update_bus);
      end
   end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: two parameter sets driven in
// parallel, checked every cycle against a history-based model.

module tb_sensor_conditioner;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic       Reset;
   logic [5:0] r;

   logic a_air, a_solo, a_temp, a_high, a_med, a_low, a_valid, a_chg;
   logic b_air, b_solo, b_temp, b_high, b_med, b_low, b_valid, b_chg;

   sensor_conditioner dut_a (
      .Clock          (Clock),
      .Reset          (Reset),
      .UmidadeArRaw   (r[5]),
      .UmidadeSoloRaw (r[4]),
      .TemperaturaRaw (r[3]),
      .HighRaw        (r[2]),
      .MediumRaw      (r[1]),
      .LowRaw         (r[0]),
      .UmidadeAr      (a_air),
      .UmidadeSolo    (a_solo),
      .Temperatura    (a_temp),
      .High           (a_high),
      .Medium         (a_med),
      .Low            (a_low),
      .Valid          (a_valid),
      .Changed        (a_chg)
   );

   sensor_conditioner #(
      .SYNC_STAGES     (3),
      .DEBOUNCE_CYCLES (1)
   ) dut_b (
      .Clock          (Clock),
      .Reset          (Reset),
      .UmidadeArRaw   (r[5]),
      .UmidadeSoloRaw (r[4]),
      .TemperaturaRaw (r[3]),
      .HighRaw        (r[2]),
      .MediumRaw      (r[1]),
      .LowRaw         (r[0]),
      .UmidadeAr      (b_air),
      .UmidadeSolo    (b_solo),
      .Temperatura    (b_temp),
      .High           (b_high),
      .Medium         (b_med),
      .Low            (b_low),
      .Valid          (b_valid),
      .Changed        (b_chg)
   );

   int errors = 0;
   int checks = 0;

   // raw value present at each edge since the last reset release
   logic [5:0] hist [0:8191];
   int         k = 0;

   logic [5:0] qa = '0, qb = '0;
   logic       va = 1'b0, vb = 1'b0, ca = 1'b0, cb = 1'b0;

   // synchronised value seen by the debouncer at edge e
   function automatic logic [5:0] s_at(int e, int s);
      if (e - s >= 1) return hist[e - s];
      return 6'b0;
   endfunction

   // channels whose last d synchronised samples all disagree with q
   function automatic logic [5:0] flips(int e, int s, int d,
                                        logic [5:0] q);
      logic [5:0] f;
      f = '1;
      if (e < d) return 6'b0;
      for (int j = 0; j < d; j++) f &= s_at(e - j, s) ^ q;
      return f;
   endfunction

   task automatic step(input logic rst);
      logic [5:0] fa, fb;
      logic [7:0] obs_a, obs_b, exp_a, exp_b;
      Reset = rst;
      @(posedge Clock);
      if (rst) begin
         k = 0; qa = '0; qb = '0;
         va = 0; vb = 0; ca = 0; cb = 0;
      end else begin
         if (k < 8191) k++;
         hist[k] = r;
         fa = flips(k, 2, 4, qa);
         fb = flips(k, 3, 1, qb);
         ca = (k - 1 >= 6) && (|fa);
         cb = (k - 1 >= 4) && (|fb);
         qa = qa ^ fa;
         qb = qb ^ fb;
         va = (k >= 6);
         vb = (k >= 4);
      end
      #1;
      obs_a = {a_air, a_solo, a_temp, a_high, a_med, a_low,
               a_valid, a_chg};
      obs_b = {b_air, b_solo, b_temp, b_high, b_med, b_low,
               b_valid, b_chg};
      exp_a = {qa, va, ca};
      exp_b = {qb, vb, cb};
      checks++;
      assert (obs_a === exp_a) else begin
         errors++;
         $error("FAIL dflt k=%0d got %b exp %b", k, obs_a, exp_a);
      end
      checks++;
      assert (obs_b === exp_b) else begin
         errors++;
         $error("FAIL s3d1 k=%0d got %b exp %b", k, obs_b, exp_b);
      end
   endtask

   initial begin
      r     = '0;
      Reset = 1'b1;
      // 1: reset, settle with all raw low
      step(1); step(1);
      repeat (8) step(0);
      // 2: High held
      r[2] = 1'b1;
      repeat (8) step(0);
      // 3: Medium bounces, then held
      repeat (5) begin
         r[1] = 1'b1; repeat (3) step(0);
         r[1] = 1'b0; repeat (2) step(0);
      end
      r[1] = 1'b1;
      repeat (8) step(0);
      // 4: Low and Temperatura together
      r[0] = 1'b1; r[3] = 1'b1;
      repeat (8) step(0);
      // 5: UmidadeSolo interrupted by reset at edge 4
      r[4] = 1'b1;
      repeat (3) step(0);
      step(1);
      repeat (10) step(0);
      // 6: UmidadeAr rise, single-sample fall, rise
      r[5] = 1'b1;
      repeat (6) step(0);
      r[5] = 1'b0; step(0);
      r[5] = 1'b1;
      repeat (8) step(0);
      // random chatter with occasional resets
      for (int n = 0; n < 800; n++) begin
         logic [5:0] m;
         m = 6'($urandom);
         m &= 6'($urandom);
         if (($urandom % 4) != 0) m &= 6'($urandom);
         r ^= m;
         step(($urandom % 120) == 0);
         if (($urandom % 8) == 0) begin
            repeat (1 + ($urandom % 6)) step(0);
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
